id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
//   Pipeline register between the decode (D) and execute (E) stages of an
//   in-order core. Captures the decoded control bits, operands, PC values and
//   register indices once per clock and presents them to the execute stage.
//
//   Per-edge priority: reset_n low > FlushE > StallE > normal load.
//   - Flush inserts a bubble: every E output goes to zero.
//   - Stall holds every E register, including ValidE.
//   - Normal load copies D to E. Side-effecting control bits (RegWrite,
//     MemWrite, Jump, Branch) are qualified with ValidD. RegWrite is also
//     suppressed for writes to x0.
//   BubbleCount counts edges that load a bubble (a flush, or a load with
//   ValidD=0). It saturates at all-ones.
//
// Ports
//   clk, reset_n           clock and asynchronous active-low reset
//   StallE, FlushE         hazard-unit controls for the E stage
//   ValidD                 decode stage holds a real instruction
//   RegWriteD..AluSrcD     1-bit decode controls
//   ResultSrcD [1:0]       result-select control
//   AluControlD [2:0]      ALU operation
//   RD1D, RD2D, PCD,
//   ImmExtD, PCPlus4D      XLEN-bit data fields
//   Rs1D, Rs2D, RdD [4:0]  register indices
//   *E outputs             registered copies, driven straight from flops
//   BubbleCount [15:0]     saturating count of bubbles entering E
// ----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,

    input  logic            StallE,
    input  logic            FlushE,

    input  logic            ValidD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            AluSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [2:0]      AluControlD,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,

    output logic            ValidE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic            AluSrcE,
    output logic [1:0]      ResultSrcE,
    output logic [2:0]      AluControlE,
    output logic [XLEN-1:0] RD1E,
    output logic [XLEN-1:0] RD2E,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] ImmExtE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [4:0]      Rs1E,
    output logic [4:0]      Rs2E,
    output logic [4:0]      RdE,

    output logic [15:0]     BubbleCount
);

    // Qualified control values presented on a normal load.
    logic reg_write_load;
    logic mem_write_load;
    logic jump_load;
    logic branch_load;

    // A bubble enters E on a flush, or on a non-stalled load of an invalid slot.
    logic bubble_edge;
    logic count_full;

    always_comb begin
        // ValidD is the first term so a 0 there masks X on the other inputs
        // when the decode slot is empty.
        reg_write_load = ValidD & RegWriteD & (RdD != 5'd0);
        mem_write_load = ValidD & MemWriteD;
        jump_load      = ValidD & JumpD;
        branch_load    = ValidD & BranchD;

        bubble_edge    = FlushE | (~StallE & ~ValidD);
        count_full     = (BubbleCount == 16'hFFFF);
    end

    // Control and valid bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            AluSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            AluControlE <= '0;
        end else if (FlushE) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            AluSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            AluControlE <= '0;
        end else if (!StallE) begin
            ValidE      <= ValidD;
            RegWriteE   <= reg_write_load;
            MemWriteE   <= mem_write_load;
            JumpE       <= jump_load;
            BranchE     <= branch_load;
            AluSrcE     <= AluSrcD;
            ResultSrcE  <= ResultSrcD;
            AluControlE <= AluControlD;
        end
    end

    // Data fields and register indices.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (FlushE) begin
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!StallE) begin
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            ImmExtE  <= ImmExtD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= RdD;
        end
    end

    // Saturating bubble counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            BubbleCount <= '0;
        end else if (bubble_edge && !count_full) begin
            BubbleCount <= BubbleCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_stage
//   Self-checking bench for id_ex_stage. A reference model computes the
//   expected E-stage state for each clock edge. That expected state is pushed
//   to a scoreboard queue when stimulus is driven, then popped and compared
//   after the edge.
// ----------------------------------------------------------------------------
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] bubbles;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        StallE, FlushE, ValidD;
    logic        RegWriteD, MemWriteD, JumpD, BranchD, AluSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  AluControlD;
    logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]  Rs1D, Rs2D, RdD;

    logic        ValidE, RegWriteE, MemWriteE, JumpE, BranchE, AluSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  AluControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [15:0] BubbleCount;

    int unsigned checks = 0;
    int unsigned errors = 0;

    out_t model;
    out_t sb[$];
    out_t got;
    out_t exp_o;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .StallE(StallE), .FlushE(FlushE),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .AluSrcD(AluSrcD),
        .ResultSrcD(ResultSrcD), .AluControlD(AluControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
        .JumpE(JumpE), .BranchE(BranchE), .AluSrcE(AluSrcE),
        .ResultSrcE(ResultSrcE), .AluControlE(AluControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE),
        .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .BubbleCount(BubbleCount)
    );

    function automatic out_t observe();
        out_t o;
        o.valid = ValidE;           o.reg_write = RegWriteE;
        o.mem_write = MemWriteE;    o.jump = JumpE;
        o.branch = BranchE;         o.alu_src = AluSrcE;
        o.result_src = ResultSrcE;  o.alu_control = AluControlE;
        o.rd1 = RD1E; o.rd2 = RD2E; o.pc = PCE; o.imm = ImmExtE; o.pc4 = PCPlus4E;
        o.rs1 = Rs1E; o.rs2 = Rs2E; o.rd = RdE;
        o.bubbles = BubbleCount;
        return o;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Reference behaviour for one rising edge, from the current bench inputs.
    function automatic out_t model_next(input out_t cur);
        out_t n;
        n = cur;
        if (!reset_n) begin
            n = '0;
        end else if (FlushE) begin
            n = '0;
            n.bubbles = sat_inc(cur.bubbles);
        end else if (!StallE) begin
            n.valid       = ValidD;
            n.reg_write   = (ValidD === 1'b1) && (RegWriteD === 1'b1) && (RdD !== 5'd0);
            n.mem_write   = (ValidD === 1'b1) && (MemWriteD === 1'b1);
            n.jump        = (ValidD === 1'b1) && (JumpD === 1'b1);
            n.branch      = (ValidD === 1'b1) && (BranchD === 1'b1);
            n.alu_src     = AluSrcD;
            n.result_src  = ResultSrcD;
            n.alu_control = AluControlD;
            n.rd1 = RD1D; n.rd2 = RD2D; n.pc = PCD; n.imm = ImmExtD; n.pc4 = PCPlus4D;
            n.rs1 = Rs1D; n.rs2 = Rs2D; n.rd = RdD;
            if (ValidD !== 1'b1) n.bubbles = sat_inc(cur.bubbles);
        end
        return n;
    endfunction

    // Drive one edge: advance the model, optionally record the expectation.
    task automatic step(input bit record);
        model = model_next(model);
        if (record) sb.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        StallE = 0; FlushE = 0; ValidD = 0;
        RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; AluSrcD = 0;
        ResultSrcD = '0; AluControlD = '0;
        RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
        Rs1D = '0; Rs2D = '0; RdD = '0;
    endtask

    task automatic randomize_d();
        ValidD = 1'($urandom_range(0, 1));
        RegWriteD = 1'($urandom_range(0, 1)); MemWriteD = 1'($urandom_range(0, 1));
        JumpD = 1'($urandom_range(0, 1));     BranchD = 1'($urandom_range(0, 1));
        AluSrcD = 1'($urandom_range(0, 1));
        ResultSrcD = 2'($urandom_range(0, 3)); AluControlD = 3'($urandom_range(0, 7));
        RD1D = $urandom; RD2D = $urandom; PCD = $urandom; ImmExtD = $urandom; PCPlus4D = $urandom;
        Rs1D = 5'($urandom_range(0, 31)); Rs2D = 5'($urandom_range(0, 31));
        RdD = 5'($urandom_range(0, 31));
    endtask

    task automatic do_reset();
        reset_n = 0;
        #3;
        model = '0;
        sb.delete();
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        model = '0;
        ValidD = 1; RegWriteD = 1; RdD = 5'd7; RD1D = 32'hDEAD_BEEF; FlushE = 1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            exp_o = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp_o) begin
                $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, exp_o);
                errors++;
            end
        end
        @(negedge clk);
        reset_n = 1;
        clear_inputs();
    endtask

    task automatic test_load();
        clear_inputs();
        ValidD = 1; RegWriteD = 1; RdD = 5'd5; RD1D = 32'h1234_5678; AluControlD = 3'b010;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp_o) begin
            $display("FAIL load got=%h exp=%h", got, exp_o);
            errors++;
        end
        checks++;
        if ({ValidE, RegWriteE, RdE, RD1E, AluControlE} !== {1'b1, 1'b1, 5'd5, 32'h1234_5678, 3'b010}) begin
            $display("FAIL load_fields got=%h exp=%h",
                     {ValidE, RegWriteE, RdE, RD1E, AluControlE},
                     {1'b1, 1'b1, 5'd5, 32'h1234_5678, 3'b010});
            errors++;
        end
    endtask

    task automatic test_stall();
        logic [15:0] bc_before;
        bc_before = BubbleCount;
        StallE = 1;
        for (int i = 0; i < 3; i++) begin
            randomize_d();
            ValidD = 0;
            step(1);
            exp_o = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp_o) begin
                $display("FAIL stall_hold[%0d] got=%h exp=%h", i, got, exp_o);
                errors++;
            end
        end
        checks++;
        if (ValidE !== 1'b1 || RD1E !== 32'h1234_5678 || BubbleCount !== bc_before) begin
            $display("FAIL stall_state got=%b/%h/%0d exp=1/12345678/%0d",
                     ValidE, RD1E, BubbleCount, bc_before);
            errors++;
        end
        StallE = 0;
    endtask

    task automatic test_flush_beats_stall();
        logic [15:0] bc_before;
        bc_before = BubbleCount;
        randomize_d();
        FlushE = 1; StallE = 1; ValidD = 1; MemWriteD = 1;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp_o) begin
            $display("FAIL flush_stall got=%h exp=%h", got, exp_o);
            errors++;
        end
        checks++;
        if (got !== {186'd0, bc_before + 16'd1}) begin
            $display("FAIL flush_zero got=%h exp=%h", got, {186'd0, bc_before + 16'd1});
            errors++;
        end
        FlushE = 0; StallE = 0;
    endtask

    task automatic test_qualification();
        clear_inputs();
        ValidD = 0; RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; RdD = 5'd3;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if ({got.valid, got.reg_write, got.mem_write, got.jump, got.branch} !== 5'b0 || got !== exp_o) begin
            $display("FAIL qual_invalid got=%h exp=%h", got, exp_o);
            errors++;
        end
        ValidD = 1; RegWriteD = 1; MemWriteD = 0; JumpD = 0; BranchD = 0; RdD = 5'd0;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got.valid !== 1'b1 || got.reg_write !== 1'b0 || got !== exp_o) begin
            $display("FAIL qual_x0 got=%h exp=%h", got, exp_o);
            errors++;
        end
        // Unknown data and index fields on an empty slot must not reach control.
        ValidD = 0; RegWriteD = 1'bx; MemWriteD = 1'bx; JumpD = 1'bx; BranchD = 1'bx;
        RD1D = 'x; RD2D = 'x; PCD = 'x; ImmExtD = 'x; PCPlus4D = 'x; RdD = 'x;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if ({ValidE, RegWriteE, MemWriteE, JumpE, BranchE} !== 5'b0 || got !== exp_o) begin
            $display("FAIL qual_xprop got=%h exp=%h", got, exp_o);
            errors++;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            randomize_d();
            FlushE = ($urandom_range(0, 7) == 0);
            StallE = ($urandom_range(0, 3) == 0);
            step(1);
            exp_o = sb.pop_front();
            got = observe();
            checks++;
            if (got !== exp_o) begin
                $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp_o);
                errors++;
            end
            checks++;
            if (ValidE === 1'b0 && {RegWriteE, MemWriteE, JumpE, BranchE} !== 4'b0) begin
                $display("FAIL invariant[%0d] got=%b exp=0000", i, {RegWriteE, MemWriteE, JumpE, BranchE});
                errors++;
            end
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        do_reset();
        clear_inputs();
        for (int i = 0; i < 65534; i++) step(0);
        checks++;
        if (BubbleCount !== 16'hFFFE) begin
            $display("FAIL sat_pre got=%h exp=fffe", BubbleCount);
            errors++;
        end
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got.bubbles !== 16'hFFFF || got !== exp_o) begin
            $display("FAIL sat_reach got=%h exp=%h", got, exp_o);
            errors++;
        end
        FlushE = 1;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got.bubbles !== 16'hFFFF || got !== exp_o) begin
            $display("FAIL sat_hold got=%h exp=%h", got, exp_o);
            errors++;
        end
        FlushE = 0;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        ValidD = 1; RegWriteD = 1; RdD = 5'd9; RD2D = 32'hCAFE_F00D; PCD = 32'h100;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp_o || ValidE !== 1'b1) begin
            $display("FAIL async_preload got=%h exp=%h", got, exp_o);
            errors++;
        end
        // Mid-cycle assertion, with stall and flush both requested.
        #2;
        StallE = 1; FlushE = 1;
        reset_n = 0;
        model = '0;
        #1;
        got = observe();
        checks++;
        if (got !== '0) begin
            $display("FAIL async_clear got=%h exp=0", got);
            errors++;
        end
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (got !== exp_o) begin
            $display("FAIL async_held got=%h exp=%h", got, exp_o);
            errors++;
        end
        @(negedge clk);
        reset_n = 1;
        StallE = 0; FlushE = 0;
        ValidD = 1; RdD = 5'd4;
        step(1);
        exp_o = sb.pop_front();
        got = observe();
        checks++;
        if (ValidE !== 1'b1 || got !== exp_o) begin
            $display("FAIL async_release got=%h exp=%h", got, exp_o);
            errors++;
        end
    endtask

    initial begin
        clear_inputs();
        reset_n = 0;
        model = '0;
        test_reset();
        test_load();
        test_stall();
        test_flush_beats_stall();
        test_qualification();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
